// File: rtl/hazard_scoreboard_unit_if.sv
// hazard_scoreboard_unit_if: pipeline hazard signals between the core datapath and the hazard unit.
interface hazard_scoreboard_unit_if #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
);
    logic            ICacheMiss, DCacheMiss;
    logic            BranchE, JalrE, JalD;
    logic            MdStartE, LoadE;
    logic [1:0]      RegReadD, RegReadE;
    logic [RA_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic            RegWriteM, RegWriteW;
    logic            StallF, StallD, StallE, StallM, StallW;
    logic            FlushF, FlushD, FlushE, FlushM, FlushW;
    logic [1:0]      Forward1E, Forward2E;
    logic            MdBusy;
    logic [CNT_W-1:0] StallCycles, RedirectCount;

    modport master (
        output ICacheMiss, DCacheMiss, BranchE, JalrE, JalD, MdStartE, LoadE,
               RegReadD, RegReadE, Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
               RegWriteM, RegWriteW,
        input  StallF, StallD, StallE, StallM, StallW,
               FlushF, FlushD, FlushE, FlushM, FlushW,
               Forward1E, Forward2E, MdBusy, StallCycles, RedirectCount
    );

    modport slave (
        input  ICacheMiss, DCacheMiss, BranchE, JalrE, JalD, MdStartE, LoadE,
               RegReadD, RegReadE, Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
               RegWriteM, RegWriteW,
        output StallF, StallD, StallE, StallM, StallW,
               FlushF, FlushD, FlushE, FlushM, FlushW,
               Forward1E, Forward2E, MdBusy, StallCycles, RedirectCount
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: stall/flush/forward control for the 5-stage core with mul/div
// occupancy tracking, load-use bubbling and saturating performance counters.
module hazard_scoreboard_unit #(
    parameter int RA_W       = 5,
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic CpuClk,
    input  logic CpuRstN,
    hazard_scoreboard_unit_if.slave hz
);
    localparam int CW = $clog2(MD_LATENCY) + 1;
    localparam logic [CW-1:0] CNT_INIT = (MD_LATENCY > 1) ? CW'(MD_LATENCY - 2) : '0;
    localparam logic [RA_W-1:0] X0 = '0;

    typedef enum logic {RUN, MD_WAIT} state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cycles, r_redirects;
    logic             w_take, w_md_stall, w_load_use, w_redirect;
    logic [4:0]       w_stall, w_flush;

    assign w_take     = (r_state == RUN) && hz.MdStartE && !hz.DCacheMiss && (MD_LATENCY > 1);
    assign w_md_stall = w_take || (r_state == MD_WAIT && r_cnt != '0);
    assign w_load_use = hz.LoadE && hz.RdE != X0 &&
                        ((hz.RegReadD[1] && hz.Rs1D == hz.RdE) || (hz.RegReadD[0] && hz.Rs2D == hz.RdE));

    always_ff @(posedge CpuClk) begin
        if (!CpuRstN) begin
            r_state        <= RUN;
            r_cnt          <= '0;
            r_stall_cycles <= '0;
            r_redirects    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (hz.StallF && r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + 1'b1;
            if (w_redirect && r_redirects != '1) r_redirects <= r_redirects + 1'b1;
        end
    end

    // The countdown keeps running under a D-cache miss; only the exit to RUN waits for it.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == RUN) begin
            if (w_take) begin
                w_state_nxt = MD_WAIT;
                w_cnt_nxt   = CNT_INIT;
            end
        end else if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
        else if (!hz.DCacheMiss) w_state_nxt = RUN;
    end

    // Vectors are {F, D, E, M, W}; earlier branches take priority.
    always_comb begin
        w_stall = '0;
        w_flush = '0;
        if (!CpuRstN) w_flush = '1;
        else if (hz.DCacheMiss) w_stall = '1;
        else if (hz.BranchE || hz.JalrE) w_flush = 5'b01100;
        else if (w_md_stall) begin
            w_stall = 5'b11100;
            w_flush = 5'b00010;
        end else if (w_load_use) begin
            w_stall = 5'b11000;
            w_flush = 5'b00100;
        end else if (hz.JalD) w_flush = 5'b01000;
        else if (hz.ICacheMiss) begin
            w_stall = 5'b10000;
            w_flush = 5'b01000;
        end
    end

    assign w_redirect = CpuRstN && !hz.DCacheMiss &&
                        (hz.BranchE || hz.JalrE || (hz.JalD && !w_md_stall && !w_load_use));

    assign {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.StallW} = w_stall;
    assign {hz.FlushF, hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW} = w_flush;

    assign hz.Forward1E = (hz.RegReadE[1] && hz.RegWriteM && hz.RdM != X0 && hz.Rs1E == hz.RdM) ? 2'b10 :
                          (hz.RegReadE[1] && hz.RegWriteW && hz.RdW != X0 && hz.Rs1E == hz.RdW) ? 2'b01 : 2'b00;
    assign hz.Forward2E = (hz.RegReadE[0] && hz.RegWriteM && hz.RdM != X0 && hz.Rs2E == hz.RdM) ? 2'b10 :
                          (hz.RegReadE[0] && hz.RegWriteW && hz.RdW != X0 && hz.Rs2E == hz.RdW) ? 2'b01 : 2'b00;

    assign hz.MdBusy        = (r_state == MD_WAIT);
    assign hz.StallCycles   = r_stall_cycles;
    assign hz.RedirectCount = r_redirects;
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb_hazard_scoreboard_unit: directed scenario tests for hazard_scoreboard_unit
// (MD_LATENCY=4); outputs are sampled on the falling edge.
module tb_hazard_scoreboard_unit;
    logic clk = 1'b0;
    logic rstn;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [4:0] stall_v, flush_v;

    always #5 clk = ~clk;

    hazard_scoreboard_unit_if #(.RA_W(5), .CNT_W(32)) hz ();

    hazard_scoreboard_unit #(.RA_W(5), .MD_LATENCY(4), .CNT_W(32)) dut (
        .CpuClk (clk),
        .CpuRstN(rstn),
        .hz     (hz)
    );

    assign stall_v = {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.StallW};
    assign flush_v = {hz.FlushF, hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW};

    task automatic idle();
        rstn = 1'b1;
        hz.ICacheMiss = 0; hz.DCacheMiss = 0; hz.BranchE = 0; hz.JalrE = 0; hz.JalD = 0;
        hz.MdStartE = 0; hz.LoadE = 0; hz.RegReadD = 0; hz.RegReadE = 0;
        hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0; hz.RdE = 0; hz.RdM = 0; hz.RdW = 0;
        hz.RegWriteM = 0; hz.RegWriteW = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rstn = 1'b0;
        next_cycle();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rstn = 1'b0;
        hz.MdStartE = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            @(negedge clk);
            n_cmp++;
            if (flush_v !== 5'b11111 || stall_v !== 5'b00000 || hz.MdBusy !== 1'b0 ||
                hz.Forward1E !== 2'b00 || hz.Forward2E !== 2'b00) begin
                n_err++;
                $display("FAIL reset_outputs c%0d: flush=%b stall=%b busy=%b f1=%b f2=%b, required 11111 00000 0 00 00",
                         c, flush_v, stall_v, hz.MdBusy, hz.Forward1E, hz.Forward2E);
            end
            n_cmp++;
            if (hz.StallCycles !== 32'd0 || hz.RedirectCount !== 32'd0) begin
                n_err++;
                $display("FAIL reset_counters c%0d: stall=%0d redirect=%0d, required 0 0", c, hz.StallCycles, hz.RedirectCount);
            end
        end
        next_cycle();
        rstn = 1'b1;
        #1;
        n_cmp++;
        if (stall_v !== 5'b11100 || flush_v !== 5'b00010) begin
            n_err++;
            $display("FAIL release_take: stall=%b flush=%b, required 11100 00010", stall_v, flush_v);
        end
        next_cycle();
        n_cmp++;
        if (hz.MdBusy !== 1'b1) begin
            n_err++;
            $display("FAIL release_busy: got %b required 1", hz.MdBusy);
        end
        do_reset();
    endtask

    task automatic test_muldiv();
        logic [4:0] es;
        do_reset();
        hz.MdStartE = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            es = (c < 4) ? 5'b11100 : 5'b00000;
            @(negedge clk);
            n_cmp++;
            if (stall_v !== es || flush_v !== (c < 4 ? 5'b00010 : 5'b00000) || hz.MdBusy !== (c > 1)) begin
                n_err++;
                $display("FAIL muldiv c%0d: stall=%b flush=%b busy=%b, required stall=%b", c, stall_v, flush_v, hz.MdBusy, es);
            end
            next_cycle();
        end
        hz.MdStartE = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (hz.MdBusy !== 1'b0 || hz.StallCycles !== 32'd3 || stall_v !== 5'b00000) begin
            n_err++;
            $display("FAIL muldiv_end: busy=%b stall_cycles=%0d stall=%b, required 0 3 00000", hz.MdBusy, hz.StallCycles, stall_v);
        end
        next_cycle();
    endtask

    task automatic test_muldiv_dmiss();
        logic [4:0] es, ef;
        do_reset();
        hz.MdStartE = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            hz.DCacheMiss = (c == 3 || c == 4);
            #1;
            es = (c <= 2) ? 5'b11100 : (c <= 4) ? 5'b11111 : 5'b00000;
            ef = (c <= 2) ? 5'b00010 : 5'b00000;
            @(negedge clk);
            n_cmp++;
            if (stall_v !== es || flush_v !== ef || hz.MdBusy !== (c > 1)) begin
                n_err++;
                $display("FAIL md_dmiss c%0d: stall=%b flush=%b busy=%b, required %b %b %b", c, stall_v, flush_v, hz.MdBusy, es, ef, c > 1);
            end
            next_cycle();
        end
        hz.MdStartE = 1'b0;
        hz.DCacheMiss = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (hz.MdBusy !== 1'b0 || hz.StallCycles !== 32'd4) begin
            n_err++;
            $display("FAIL md_dmiss_end: busy=%b stall_cycles=%0d, required 0 4", hz.MdBusy, hz.StallCycles);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        do_reset();
        hz.LoadE = 1'b1; hz.RdE = 5; hz.Rs2D = 5; hz.RegReadD = 2'b01;
        @(negedge clk);
        n_cmp++;
        if (stall_v !== 5'b11000 || flush_v !== 5'b00100) begin
            n_err++;
            $display("FAIL load_use_rs2: stall=%b flush=%b, required 11000 00100", stall_v, flush_v);
        end
        next_cycle();
        hz.RdE = 0; hz.Rs2D = 0;
        @(negedge clk);
        n_cmp++;
        if (stall_v !== 5'b00000 || flush_v !== 5'b00000) begin
            n_err++;
            $display("FAIL load_use_x0: stall=%b flush=%b, required 00000 00000", stall_v, flush_v);
        end
        next_cycle();
        hz.RdE = 5; hz.Rs2D = 5; hz.RegReadD = 2'b00;
        @(negedge clk);
        n_cmp++;
        if (stall_v !== 5'b00000 || flush_v !== 5'b00000) begin
            n_err++;
            $display("FAIL load_use_noread: stall=%b flush=%b, required 00000 00000", stall_v, flush_v);
        end
        next_cycle();
        hz.Rs2D = 0; hz.Rs1D = 5; hz.RegReadD = 2'b10;
        @(negedge clk);
        n_cmp++;
        if (stall_v !== 5'b11000 || flush_v !== 5'b00100) begin
            n_err++;
            $display("FAIL load_use_rs1: stall=%b flush=%b, required 11000 00100", stall_v, flush_v);
        end
        next_cycle();
        idle();
        @(negedge clk);
        n_cmp++;
        if (hz.StallCycles !== 32'd2 || hz.RedirectCount !== 32'd0) begin
            n_err++;
            $display("FAIL load_use_count: stall_cycles=%0d redirect=%0d, required 2 0", hz.StallCycles, hz.RedirectCount);
        end
        next_cycle();
    endtask

    task automatic test_priority();
        do_reset();
        hz.BranchE = 1'b1; hz.ICacheMiss = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (stall_v !== 5'b00000 || flush_v !== 5'b01100) begin
            n_err++;
            $display("FAIL branch_over_imiss: stall=%b flush=%b, required 00000 01100", stall_v, flush_v);
        end
        next_cycle();
        hz.DCacheMiss = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (stall_v !== 5'b11111 || flush_v !== 5'b00000 || hz.RedirectCount !== 32'd1) begin
            n_err++;
            $display("FAIL dmiss_over_branch: stall=%b flush=%b redirect=%0d, required 11111 00000 1", stall_v, flush_v, hz.RedirectCount);
        end
        next_cycle();
        hz.DCacheMiss = 1'b0; hz.BranchE = 1'b0; hz.JalD = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (stall_v !== 5'b00000 || flush_v !== 5'b01000 || hz.RedirectCount !== 32'd1) begin
            n_err++;
            $display("FAIL jald_over_imiss: stall=%b flush=%b redirect=%0d, required 00000 01000 1", stall_v, flush_v, hz.RedirectCount);
        end
        next_cycle();
        hz.JalD = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (stall_v !== 5'b10000 || flush_v !== 5'b01000 || hz.RedirectCount !== 32'd2) begin
            n_err++;
            $display("FAIL imiss_only: stall=%b flush=%b redirect=%0d, required 10000 01000 2", stall_v, flush_v, hz.RedirectCount);
        end
        next_cycle();
        idle();
        hz.JalrE = 1'b1; hz.LoadE = 1'b1; hz.RdE = 3; hz.Rs1D = 3; hz.RegReadD = 2'b10;
        @(negedge clk);
        n_cmp++;
        if (stall_v !== 5'b00000 || flush_v !== 5'b01100) begin
            n_err++;
            $display("FAIL jalr_over_loaduse: stall=%b flush=%b, required 00000 01100", stall_v, flush_v);
        end
        next_cycle();
        idle();
        @(negedge clk);
        n_cmp++;
        if (hz.RedirectCount !== 32'd3 || hz.StallCycles !== 32'd2) begin
            n_err++;
            $display("FAIL priority_count: redirect=%0d stall_cycles=%0d, required 3 2", hz.RedirectCount, hz.StallCycles);
        end
        next_cycle();
    endtask

    task automatic test_forwarding();
        do_reset();
        hz.RegReadE = 2'b11; hz.RdM = 7; hz.RdW = 7; hz.Rs1E = 7; hz.Rs2E = 4;
        hz.RegWriteM = 1'b1; hz.RegWriteW = 1'b1;
        #1;
        n_cmp++;
        if (hz.Forward1E !== 2'b10 || hz.Forward2E !== 2'b00) begin
            n_err++;
            $display("FAIL fwd_m_priority: f1=%b f2=%b, required 10 00", hz.Forward1E, hz.Forward2E);
        end
        hz.RegWriteM = 1'b0;
        #1;
        n_cmp++;
        if (hz.Forward1E !== 2'b01) begin
            n_err++;
            $display("FAIL fwd_w: got %b required 01", hz.Forward1E);
        end
        hz.Rs1E = 0;
        #1;
        n_cmp++;
        if (hz.Forward1E !== 2'b00) begin
            n_err++;
            $display("FAIL fwd_rs1_x0: got %b required 00", hz.Forward1E);
        end
        hz.Rs1E = 7; hz.RegReadE = 2'b01; hz.Rs2E = 7; hz.RegWriteM = 1'b1;
        #1;
        n_cmp++;
        if (hz.Forward1E !== 2'b00 || hz.Forward2E !== 2'b10) begin
            n_err++;
            $display("FAIL fwd_rs2: f1=%b f2=%b, required 00 10", hz.Forward1E, hz.Forward2E);
        end
        hz.RdM = 0; hz.Rs2E = 0; hz.RdW = 0;
        #1;
        n_cmp++;
        if (hz.Forward2E !== 2'b00) begin
            n_err++;
            $display("FAIL fwd_x0_dest: got %b required 00", hz.Forward2E);
        end
        idle();
        next_cycle();
    endtask

    initial begin
        idle();
        next_cycle();
        test_reset();
        test_muldiv();
        test_muldiv_dmiss();
        test_load_use();
        test_priority();
        test_forwarding();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
